fetch_decode: RTL and testbench

//   Front-end stage feeding the memory block: drives the 15-bit PC to the instruction memory.

---
 rtl/fetch_decode.sv | 83 ++++++++
 tb/tb_fetch_decode.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode.sv
// fetch_decode: fetch/decode front end, FETCH->WAIT->ISSUE handshake with execute.
// Optional macro ILLEGAL_TRAP_EN: undefined opcodes halt the core and set a sticky illegal_op.
module fetch_decode #(
  parameter int PC_W = 15,
  parameter int INSTR_W = 24,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               fetch_clk,
  input  logic               fetch_rst_n,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [INSTR_W-1:0] rs1_data,
  input  logic               exec_ready,
  output logic [PC_W-1:0]    fetch_PC,
  output logic               instr_valid,
  output logic [3:0]         opcode,
  output logic [3:0]         rd,
  output logic [3:0]         rs1,
  output logic [3:0]         rs2,
  output logic [7:0]         imm,
  output logic [7:0]         mem_addr,
  output logic               we_load_mem,
  output logic               we_store_mem,
  output logic               halted,
  output logic               illegal_op
);
  typedef enum logic [1:0] {FETCH, WAIT, ISSUE, HALT} state_t;
  localparam logic [3:0] OP_JMP = 4'h7, OP_LD = 4'hA, OP_ST = 4'hB, OP_HALT = 4'hF;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic trap, stop, unused;
  assign unused = ^{rs1_data[INSTR_W-1:PC_W], ir_q[15:12]};
  assign opcode = ir_q[23:20];
  assign rd = (opcode == OP_LD) ? ir_q[3:0] : ir_q[19:16];
  assign rs1 = ir_q[11:8];
  assign rs2 = ir_q[3:0];
  assign imm = ir_q[7:0];
  assign mem_addr = ir_q[11:4];
  assign fetch_PC = pc_q;
  assign instr_valid = (state_q == ISSUE);
  assign we_load_mem = instr_valid && (opcode == OP_LD);
  assign we_store_mem = instr_valid && (opcode == OP_ST);
  assign halted = (state_q == HALT);
  assign stop = (opcode == OP_HALT) || trap;
`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign trap = !(opcode inside {4'h0, 4'h3, 4'h7, 4'h8, 4'hA, 4'hB, 4'hD, 4'hF});
  assign illegal_op = illegal_q;
  always_ff @(posedge fetch_clk or negedge fetch_rst_n)
    if (!fetch_rst_n) illegal_q <= 1'b0;
    else if (instr_valid && exec_ready && trap) illegal_q <= 1'b1;
`else
  assign trap = 1'b0;
  assign illegal_op = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    case (state_q)
      FETCH: state_d = WAIT;
      WAIT: begin
        ir_d = instr_in;
        state_d = ISSUE;
      end
      ISSUE: if (exec_ready) begin
        state_d = stop ? HALT : FETCH;
        pc_d = stop ? pc_q : (opcode == OP_JMP) ? rs1_data[PC_W-1:0] : pc_q + PC_W'(1);
      end
      default: ;
    endcase
  end
  always_ff @(posedge fetch_clk or negedge fetch_rst_n)
    if (!fetch_rst_n) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      ir_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: scoreboard bench for fetch_decode with a synchronous 1-cycle instruction memory.
module tb_fetch_decode;
  logic clk = 1'b0, rst_n = 1'b0, exec_ready = 1'b0;
  logic [23:0] instr_in = '0, rs1_data = '0;
  logic [14:0] fetch_PC;
  logic instr_valid, we_load_mem, we_store_mem, halted, illegal_op;
  logic [3:0] opcode, rd, rs1, rs2;
  logic [7:0] imm, mem_addr;
  logic [23:0] mem [0:32767];
  int errors = 0, checks = 0;
  typedef logic [48:0] rec_t;
  rec_t exp_q[$];
  rec_t r;
  bit ok;
  int n;

  fetch_decode dut (
    .fetch_clk(clk), .fetch_rst_n(rst_n), .instr_in(instr_in), .rs1_data(rs1_data),
    .exec_ready(exec_ready), .fetch_PC(fetch_PC), .instr_valid(instr_valid), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .mem_addr(mem_addr), .we_load_mem(we_load_mem),
    .we_store_mem(we_store_mem), .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;
  always @(posedge clk) instr_in <= mem[fetch_PC];

  function automatic rec_t model(logic [14:0] pc, logic [23:0] i);
    logic [3:0] op;
    op = i[23:20];
    return {pc, op, (op == 4'hA) ? i[3:0] : i[19:16], i[11:8], i[3:0], i[7:0], i[11:4],
            op == 4'hA, op == 4'hB};
  endfunction

  function automatic rec_t observe();
    return {fetch_PC, opcode, rd, rs1, rs2, imm, mem_addr, we_load_mem, we_store_mem};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 32768; i++) mem[i] = 24'h800000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_issue(output bit found, output int cnt);
    found = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      cnt++;
      found = instr_valid;
    end
  endtask

  task automatic test_reset();
    exec_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({fetch_PC, instr_valid, we_load_mem, we_store_mem, halted, illegal_op, opcode} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got pc=%h v=%b wl=%b ws=%b h=%b il=%b op=%h exp all 0",
               fetch_PC, instr_valid, we_load_mem, we_store_mem, halted, illegal_op, opcode);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || fetch_PC !== 15'd0) begin
      errors++;
      $display("FAIL reset_first_cycle got v=%b pc=%h exp v=0 pc=0", instr_valid, fetch_PC);
    end
  endtask

  task automatic test_back_to_back();
    clear_mem();
    mem[0] = 24'hA00011;
    mem[1] = 24'hB000A3;
    exp_q.push_back(model(15'd0, 24'hA00011));
    exp_q.push_back(model(15'd1, 24'hB000A3));
    exec_ready = 1'b1;
    do_reset();
    wait_issue(ok, n);
    checks++;
    if (!ok || n != 2) begin
      errors++;
      $display("FAIL ld_latency got found=%b cycles=%0d exp found=1 cycles=2", ok, n);
    end
    r = exp_q.pop_front();
    checks++;
    if (observe() !== r) begin
      errors++;
      $display("FAIL ld_decode got %h exp %h", observe(), r);
    end
    checks++;
    if ({rd, mem_addr, we_load_mem, we_store_mem} !== {4'd1, 8'h01, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ld_fields got rd=%h ma=%h wl=%b ws=%b exp 1 01 1 0", rd, mem_addr, we_load_mem, we_store_mem);
    end
    @(negedge clk);
    checks++;
    if (fetch_PC !== 15'd1 || instr_valid !== 1'b0 || we_load_mem !== 1'b0) begin
      errors++;
      $display("FAIL ld_advance got pc=%h v=%b wl=%b exp pc=1 v=0 wl=0", fetch_PC, instr_valid, we_load_mem);
    end
    wait_issue(ok, n);
    checks++;
    if (!ok || n != 2) begin
      errors++;
      $display("FAIL st_latency got found=%b cycles=%0d exp found=1 cycles=2", ok, n);
    end
    r = exp_q.pop_front();
    checks++;
    if (observe() !== r || {rs2, mem_addr, we_store_mem, we_load_mem} !== {4'd3, 8'h0A, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL st_decode got %h exp %h", observe(), r);
    end
  endtask

  task automatic test_stall();
    clear_mem();
    mem[0] = 24'hDB0A03;
    exp_q.push_back(model(15'd0, 24'hDB0A03));
    exec_ready = 1'b0;
    do_reset();
    wait_issue(ok, n);
    r = exp_q.pop_front();
    checks++;
    if (!ok || {rd, rs1, imm} !== {4'd11, 4'd10, 8'h03}) begin
      errors++;
      $display("FAIL stall_fields got v=%b rd=%0d rs1=%0d imm=%h exp 1 11 10 03", ok, rd, rs1, imm);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (observe() !== r || instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold_%0d got %h v=%b exp %h v=1", k, observe(), instr_valid, r);
      end
      @(negedge clk);
    end
    exec_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (fetch_PC !== 15'd1 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got pc=%h v=%b exp pc=1 v=0", fetch_PC, instr_valid);
    end
  endtask

  task automatic test_jump_wrap();
    clear_mem();
    mem[0] = 24'h700100;
    mem[3] = 24'h700100;
    mem[32767] = 24'hD12345;
    exp_q.push_back(model(15'd0, 24'h700100));
    exp_q.push_back(model(15'd3, 24'h700100));
    exp_q.push_back(model(15'h7FFF, 24'hD12345));
    exec_ready = 1'b1;
    rs1_data = 24'hFF8003;
    do_reset();
    wait_issue(ok, n);
    r = exp_q.pop_front();
    checks++;
    if (!ok || observe() !== r) begin
      errors++;
      $display("FAIL jmp1_decode got %h exp %h", observe(), r);
    end
    @(negedge clk);
    checks++;
    if (fetch_PC !== 15'd3) begin
      errors++;
      $display("FAIL jmp1_target got pc=%h exp 0003", fetch_PC);
    end
    rs1_data = 24'h007FFF;
    wait_issue(ok, n);
    r = exp_q.pop_front();
    checks++;
    if (!ok || observe() !== r) begin
      errors++;
      $display("FAIL jmp2_decode got %h exp %h", observe(), r);
    end
    @(negedge clk);
    checks++;
    if (fetch_PC !== 15'h7FFF) begin
      errors++;
      $display("FAIL jmp2_target got pc=%h exp 7fff", fetch_PC);
    end
    rs1_data = 24'h000055;
    wait_issue(ok, n);
    r = exp_q.pop_front();
    checks++;
    if (!ok || observe() !== r) begin
      errors++;
      $display("FAIL wrap_decode got %h exp %h", observe(), r);
    end
    @(negedge clk);
    checks++;
    if (fetch_PC !== 15'd0) begin
      errors++;
      $display("FAIL pc_wrap got pc=%h exp 0000", fetch_PC);
    end
  endtask

  task automatic test_halt();
    clear_mem();
    mem[0] = 24'hF00000;
    exp_q.push_back(model(15'd0, 24'hF00000));
    exec_ready = 1'b1;
    do_reset();
    wait_issue(ok, n);
    r = exp_q.pop_front();
    checks++;
    if (!ok || observe() !== r || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_issue got %h h=%b exp %h h=0", observe(), halted, r);
    end
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if ({halted, instr_valid, fetch_PC, we_load_mem, we_store_mem} !== {1'b1, 1'b0, 15'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL halt_frozen_%0d got h=%b v=%b pc=%h exp h=1 v=0 pc=0", k, halted, instr_valid, fetch_PC);
      end
      exec_ready = k[0];
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    clear_mem();
    mem[0] = 24'h123456;
    exp_q.push_back(model(15'd0, 24'h123456));
    exec_ready = 1'b1;
    do_reset();
    wait_issue(ok, n);
    r = exp_q.pop_front();
    checks++;
    if (!ok || observe() !== r || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL illegal_issue got %h il=%b exp %h il=0", observe(), illegal_op, r);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
`ifdef ILLEGAL_TRAP_EN
    if ({halted, illegal_op, fetch_PC} !== {1'b1, 1'b1, 15'd0}) begin
      errors++;
      $display("FAIL illegal_trap got h=%b il=%b pc=%h exp h=1 il=1 pc=0", halted, illegal_op, fetch_PC);
    end
`else
    if ({halted, illegal_op, fetch_PC} !== {1'b0, 1'b0, 15'd1}) begin
      errors++;
      $display("FAIL illegal_nop got h=%b il=%b pc=%h exp h=0 il=0 pc=1", halted, illegal_op, fetch_PC);
    end
`endif
  endtask

  task automatic test_reset_mid();
    clear_mem();
    mem[0] = 24'hA00011;
    exec_ready = 1'b0;
    do_reset();
    wait_issue(ok, n);
    checks++;
    if (!ok || we_load_mem !== 1'b1) begin
      errors++;
      $display("FAIL mid_ld_issue got v=%b wl=%b exp v=1 wl=1", instr_valid, we_load_mem);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({we_load_mem, instr_valid, fetch_PC, halted} !== '0) begin
      errors++;
      $display("FAIL mid_reset got wl=%b v=%b pc=%h h=%b exp all 0", we_load_mem, instr_valid, fetch_PC, halted);
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d entries exp 0", exp_q.size());
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_back_to_back();
    test_stall();
    test_jump_wrap();
    test_halt();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
